stream_mux_nto1: RTL and testbench

Parametrised N-to-1 stream multiplexer with valid/ready handshakes and one registered output stage. It is the next generation of the team's 4-to-1 combinational data mux. It selects either a fixed channel from `sel` or a round-robin winner among valid channels, and tags each output beat with its source channel. It sits between multiple producers and a single downstream consumer, such as a shared bus or link.

---
 rtl/stream_mux_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/stream_mux_nto1.sv | 144 ++++++++++++++
 tb/tb_stream_mux_nto1.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// ---------------------------------------------------------------------------
// stream_mux_pkg
// Shared definitions for the N-to-1 stream multiplexer.
//   muxModeE   : channel selection mode (MODE_FIXED uses sel, MODE_RR rotates)
//   wrapIndex  : modulo-N index helper used by the round-robin search
// ---------------------------------------------------------------------------
package stream_mux_pkg;

  // Selection mode carried on the one-bit mode input of the top level.
  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } muxModeE;

  // Returns (base + offset) mod n.  The modulo is taken explicitly so the
  // search wraps correctly for channel counts that are not a power of two.
  function automatic int wrapIndex(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter.  The request vector is searched
// starting just after the last winner (i_ptr) and wrapping modulo N, so the
// previous winner itself is considered last.
// Ports:
//   i_req       in  N     request vector, one bit per channel
//   i_ptr       in  SELW  index of the previous winner
//   o_gnt_valid out 1     at least one request is present
//   o_gnt_idx   out SELW  index of the granted channel (0 when none)
// ---------------------------------------------------------------------------
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [SELW-1:0] i_ptr,
  output logic            o_gnt_valid,
  output logic [SELW-1:0] o_gnt_idx
);

  // Walk the rotated search order from its far end back to its near end.
  // Each hit overwrites the previous one, so the request closest to ptr+1
  // is what remains, which is the rotate-then-priority-encode result.
  always_comb begin
    o_gnt_valid = 1'b0;
    o_gnt_idx   = '0;
    for (int k = N; k >= 1; k--) begin
      int idx;
      idx = wrapIndex(int'(i_ptr), k, N);
      if (i_req[idx]) begin
        o_gnt_valid = 1'b1;
        o_gnt_idx   = SELW'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux_nto1.sv
// ---------------------------------------------------------------------------
// stream_mux_nto1
// N-to-1 valid/ready stream multiplexer with a single registered output
// stage.  The source channel is picked either directly from i_sel (FIXED)
// or by a round-robin arbiter over the valid channels (RR).  Each output
// beat carries the index of the channel it came from.
// Ports:
//   i_clk       in  1        clock, rising edge
//   i_rst       in  1        synchronous active-high reset
//   i_mode      in  1        0 = FIXED, 1 = round-robin
//   i_sel       in  SELW     channel used in FIXED mode (>= N selects none)
//   i_in_data   in  N*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   i_in_valid  in  N        per-channel valid
//   o_in_ready  out N        per-channel ready, combinational, one-hot or zero
//   o_out_data  out WIDTH    registered output data
//   o_out_ch    out SELW     registered source channel of the output beat
//   o_out_valid out 1        registered output valid
//   i_out_ready in  1        downstream ready
// ---------------------------------------------------------------------------
module stream_mux_nto1
  import stream_mux_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_mode,
  input  logic [SELW-1:0]      i_sel,
  input  logic [N*WIDTH-1:0]   i_in_data,
  input  logic [N-1:0]         i_in_valid,
  output logic [N-1:0]         o_in_ready,
  output logic [WIDTH-1:0]     o_out_data,
  output logic [SELW-1:0]      o_out_ch,
  output logic                 o_out_valid,
  input  logic                 i_out_ready
);

  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_ch;
  logic             r_out_valid;
  logic [SELW-1:0]  r_ptr;

  logic             w_accept;
  logic             w_fix_valid;
  logic             w_rr_valid;
  logic [SELW-1:0]  w_rr_idx;
  logic             w_gnt_valid;
  logic [SELW-1:0]  w_gnt_idx;
  logic             w_xfer;
  logic [WIDTH-1:0] w_sel_data;

  // The output register can take a new beat when it is empty or when its
  // current beat leaves this cycle, which lets drain and refill overlap.
  assign w_accept = !r_out_valid || i_out_ready;

  // FIXED-mode grant.  Comparing against every legal index keeps a sel
  // value of N or above from ever indexing past the valid vector.
  always_comb begin
    w_fix_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (int'(i_sel) == i && i_in_valid[i]) begin
        w_fix_valid = 1'b1;
      end
    end
  end

  rr_arbiter #(
    .N (N)
  ) u_rr_arbiter (
    .i_req       (i_in_valid),
    .i_ptr       (r_ptr),
    .o_gnt_valid (w_rr_valid),
    .o_gnt_idx   (w_rr_idx)
  );

  // Mode mux: mode and sel act on the grant of the current cycle only.
  always_comb begin
    if (i_mode == MODE_RR) begin
      w_gnt_valid = w_rr_valid;
      w_gnt_idx   = w_rr_idx;
    end else begin
      w_gnt_valid = w_fix_valid;
      w_gnt_idx   = i_sel;
    end
  end

  // An input transfer needs a grant, room in the output register, and no
  // reset in progress.  Ready is suppressed during reset so no producer
  // believes its beat was taken by a cycle that discards it.
  assign w_xfer = !i_rst && w_gnt_valid && w_accept;

  // Only the granted channel sees ready, so at most one bit is ever set.
  always_comb begin
    o_in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (w_xfer && int'(w_gnt_idx) == i) begin
        o_in_ready[i] = 1'b1;
      end
    end
  end

  // Data of the granted channel, selected with an index comparison so an
  // out-of-range index yields zero rather than an out-of-bounds slice.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(w_gnt_idx) == i) begin
        w_sel_data = i_in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register and round-robin pointer.  Under backpressure nothing
  // changes.  When the register can accept but nothing is granted, the
  // beat is dropped from valid while data and channel keep their last
  // values.  The pointer follows the winner only in RR mode so switching
  // back to RR resumes the rotation where it left off.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_ptr       <= SELW'(N - 1);
    end else if (w_accept) begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_ch    <= w_gnt_idx;
        if (i_mode == MODE_RR) begin
          r_ptr <= w_gnt_idx;
        end
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_ch    = r_out_ch;
  assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_stream_mux_nto1.sv
// ---------------------------------------------------------------------------
// tb_stream_mux_nto1
// Directed bench for the 4-channel, 4-bit configuration of stream_mux_nto1.
// Inputs change 1 time unit after a rising edge; ready is checked before the
// next edge and the registered outputs 1 time unit after it.
// ---------------------------------------------------------------------------
module tb_stream_mux_nto1;

  localparam int WIDTH = 4;
  localparam int N     = 4;
  localparam int SELW  = 2;

  logic               clk;
  logic               rst;
  logic               mode;
  logic [SELW-1:0]    sel;
  logic [N*WIDTH-1:0] inData;
  logic [N-1:0]       inValid;
  logic [N-1:0]       inReady;
  logic [WIDTH-1:0]   outData;
  logic [SELW-1:0]    outCh;
  logic               outValid;
  logic               outReady;

  logic [WIDTH-1:0]   dataArr [N];

  int compared;
  int mismatched;

  stream_mux_nto1 #(
    .WIDTH (WIDTH),
    .N     (N)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_mode      (mode),
    .i_sel       (sel),
    .i_in_data   (inData),
    .i_in_valid  (inValid),
    .o_in_ready  (inReady),
    .o_out_data  (outData),
    .o_out_ch    (outCh),
    .o_out_valid (outValid),
    .i_out_ready (outReady)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a broken design can never hang the run.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] time limit reached");
  end

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives all control inputs and packs the per-channel data array.
  task automatic applyStimulus(input logic r, input logic m, input logic [SELW-1:0] s,
                               input logic [N-1:0] v, input logic oR);
    rst      = r;
    mode     = m;
    sel      = s;
    inValid  = v;
    outReady = oR;
    for (int i = 0; i < N; i++) begin
      inData[i*WIDTH +: WIDTH] = dataArr[i];
    end
    #1;
  endtask

  // Advances past the next rising edge to a stable sampling point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the three registered outputs in one call.
  task automatic checkRegs(input string tag, input logic v, input logic [WIDTH-1:0] d,
                           input logic [SELW-1:0] c);
    checkOutput({tag, ".valid"}, 32'(outValid), 32'(v));
    checkOutput({tag, ".data"},  32'(outData),  32'(d));
    checkOutput({tag, ".ch"},    32'(outCh),    32'(c));
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    for (int i = 0; i < N; i++) dataArr[i] = WIDTH'(i + 4);

    // Reset held for two cycles with every channel valid.
    applyStimulus(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1);
    for (int c = 0; c < 2; c++) begin
      checkOutput($sformatf("rst_ready%0d", c), 32'(inReady), 32'h0);
      tick();
      checkRegs($sformatf("rst_regs%0d", c), 1'b0, 4'h0, 2'd0);
    end

    // RR rotation from reset: 0,1,2,3,0,1 with data i+4.
    applyStimulus(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1);
    for (int c = 0; c < 6; c++) begin
      checkOutput($sformatf("rr_ready%0d", c), 32'(inReady), 32'(1 << (c % 4)));
      tick();
      checkRegs($sformatf("rr_out%0d", c), 1'b1, WIDTH'((c % 4) + 4), SELW'(c % 4));
    end

    // Backpressure for three cycles: ready off, outputs frozen on channel 1.
    applyStimulus(1'b0, 1'b1, 2'd0, 4'b1111, 1'b0);
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("bp_ready%0d", c), 32'(inReady), 32'h0);
      tick();
      checkRegs($sformatf("bp_hold%0d", c), 1'b1, 4'h5, 2'd1);
    end

    // Release: the rotation continues after the previous winner (1 -> 2).
    applyStimulus(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1);
    checkOutput("bp_release_ready", 32'(inReady), 32'b0100);
    tick();
    checkRegs("bp_release_out", 1'b1, 4'h6, 2'd2);

    // Move ptr to 3, then sparse requests exercising the wrap to channel 1.
    applyStimulus(1'b0, 1'b1, 2'd0, 4'b1000, 1'b1);
    checkOutput("sp_ready_a", 32'(inReady), 32'b1000);
    tick();
    checkRegs("sp_out_a", 1'b1, 4'h7, 2'd3);
    applyStimulus(1'b0, 1'b1, 2'd0, 4'b1010, 1'b1);
    checkOutput("wrap_ready", 32'(inReady), 32'b0010);
    tick();
    checkRegs("wrap_out", 1'b1, 4'h5, 2'd1);
    applyStimulus(1'b0, 1'b1, 2'd0, 4'b1000, 1'b1);
    checkOutput("sp_ready_b", 32'(inReady), 32'b1000);
    tick();
    checkRegs("sp_out_b", 1'b1, 4'h7, 2'd3);

    // FIXED pass-through of channel 2 carrying 4'hA.
    dataArr[0] = 4'h3;
    dataArr[1] = 4'h9;
    dataArr[2] = 4'hA;
    dataArr[3] = 4'hC;
    applyStimulus(1'b0, 1'b0, 2'd2, 4'b0111, 1'b1);
    checkOutput("fix_ready", 32'(inReady), 32'b0100);
    tick();
    checkRegs("fix_out", 1'b1, 4'hA, 2'd2);

    // Selected channel not valid: no grant, valid drops, data and ch hold.
    applyStimulus(1'b0, 1'b0, 2'd3, 4'b0111, 1'b1);
    checkOutput("nosel_ready", 32'(inReady), 32'h0);
    tick();
    checkRegs("nosel_out", 1'b0, 4'hA, 2'd2);

    // Switch to RR: ptr is still 3 from the last RR winner, so channel 0.
    applyStimulus(1'b0, 1'b1, 2'd3, 4'b0111, 1'b1);
    checkOutput("sw_ready_a", 32'(inReady), 32'b0001);
    tick();
    checkRegs("sw_out_a", 1'b1, 4'h3, 2'd0);
    checkOutput("sw_ready_b", 32'(inReady), 32'b0010);
    tick();
    checkRegs("sw_out_b", 1'b1, 4'h9, 2'd1);
    applyStimulus(1'b0, 1'b0, 2'd2, 4'b0111, 1'b1);
    checkOutput("sw_ready_c", 32'(inReady), 32'b0100);
    tick();
    checkRegs("sw_out_c", 1'b1, 4'hA, 2'd2);

    // Reset mid-stream discards the pending beat and restores channel 0 priority.
    applyStimulus(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1);
    checkOutput("midrst_ready", 32'(inReady), 32'h0);
    tick();
    checkRegs("midrst_regs", 1'b0, 4'h0, 2'd0);
    applyStimulus(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1);
    checkOutput("postrst_ready", 32'(inReady), 32'b0001);
    tick();
    checkRegs("postrst_out", 1'b1, 4'h3, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
